// File: rtl/approx_mult_err_sweep.sv
// Exhaustive error-characterisation sweep for an approximate W x W multiplier.
// Issues every (A,B) pair once, aligns the exact product with the returned R and accumulates error stats.
module approx_mult_err_sweep #(
  parameter int W       = 8,
  parameter int MUL_LAT = 0,
  parameter int SUM_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   approx_r,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam int EW = 2*W + 1;
  localparam int CW = $clog2(MUL_LAT + 3);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(MUL_LAT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_drain_cnt;
  logic            r_issue;
  logic            w_start_ok;
  logic            w_last;

  logic            w_d_v;
  logic [W-1:0]    w_d_a;
  logic [W-1:0]    w_d_b;
  logic [2*W-1:0]  w_exact;
  logic [2*W-1:0]  w_ed;

  logic            r_c_v;
  logic [2*W-1:0]  r_c_ed;
  logic [W-1:0]    r_c_a;
  logic [W-1:0]    r_c_b;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (op_a == '1) && (op_b == '1);

  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_SWEEP;
      S_SWEEP:        if (!r_issue) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (r_drain_cnt == '0) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_SWEEP) || (w_state_nxt == S_DRAIN);
      done    <= (w_state_nxt == S_DONE);
      if ((r_state == S_SWEEP) && !r_issue)
        r_drain_cnt <= DRAIN_LOAD;
      else if ((r_state == S_DRAIN) && (r_drain_cnt != '0))
        r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Operand generator: r_issue marks the cycles in which op_a/op_b carry a pair under test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      r_issue <= 1'b0;
    end else if (w_start_ok) begin
      op_a    <= '0;
      op_b    <= '0;
      r_issue <= 1'b1;
    end else if (r_issue) begin
      if (w_last) begin
        r_issue <= 1'b0;
      end else begin
        op_b <= op_b + 1'b1;
        if (op_b == '1) op_a <= op_a + 1'b1;
      end
    end
  end

  // Operands and valid travel alongside the multiplier so they meet the matching R.
  generate
    if (MUL_LAT == 0) begin : g_no_delay
      assign w_d_v = r_issue;
      assign w_d_a = op_a;
      assign w_d_b = op_b;
    end else begin : g_delay
      logic [MUL_LAT-1:0]        r_dl_v;
      logic [MUL_LAT-1:0][W-1:0] r_dl_a;
      logic [MUL_LAT-1:0][W-1:0] r_dl_b;

      // NOTE: the delay line is reset as a whole; it is tiny and a stale valid must never survive a reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dl_v <= '0;
          r_dl_a <= '0;
          r_dl_b <= '0;
        end else begin
          r_dl_v[0] <= r_issue;
          r_dl_a[0] <= op_a;
          r_dl_b[0] <= op_b;
          for (int i = 1; i < MUL_LAT; i++) begin
            r_dl_v[i] <= r_dl_v[i-1];
            r_dl_a[i] <= r_dl_a[i-1];
            r_dl_b[i] <= r_dl_b[i-1];
          end
        end
      end

      assign w_d_v = r_dl_v[MUL_LAT-1];
      assign w_d_a = r_dl_a[MUL_LAT-1];
      assign w_d_b = r_dl_b[MUL_LAT-1];
    end
  endgenerate

  assign w_exact = {{W{1'b0}}, w_d_a} * {{W{1'b0}}, w_d_b};
  assign w_ed    = (w_exact >= approx_r) ? (w_exact - approx_r) : (approx_r - w_exact);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_v  <= 1'b0;
      r_c_ed <= '0;
      r_c_a  <= '0;
      r_c_b  <= '0;
    end else begin
      r_c_v  <= w_d_v;
      r_c_ed <= w_ed;
      r_c_a  <= w_d_a;
      r_c_b  <= w_d_b;
    end
  end

  // Statistics: strict > keeps the earliest pair in sweep order on ties; sum wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (w_start_ok) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (r_c_v) begin
      err_cnt <= err_cnt + EW'(r_c_ed != '0);
      sum_ed  <= sum_ed + SUM_W'(r_c_ed);
      if (r_c_ed > max_ed) begin
        max_ed <= r_c_ed;
        max_a  <= r_c_a;
        max_b  <= r_c_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_sweep.sv
// Self-checking bench: two small sweepers (latency 0 and 2) driven by behavioural multiplier models,
// with expected statistics recomputed from the sweep definition by plain arithmetic.
module tb_approx_mult_err_sweep;

  localparam int W   = 4;
  localparam int N   = 1 << (2*W);
  localparam int SW0 = 32;
  localparam int SW2 = 12;

  typedef struct {
    longint cnt;
    longint sum;
    longint mx;
    longint ma;
    longint mb;
  } stats_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [W-1:0]     a0, b0, ma0, mb0, a2, b2, ma2, mb2;
  logic [2*W-1:0]   r0, r2, mx0, mx2;
  logic             busy0, done0, busy2, done2;
  logic [2*W:0]     cnt0, cnt2;
  logic [SW0-1:0]   sum0;
  logic [SW2-1:0]   sum2;

  int mode;
  int mis2;
  logic [2*W-1:0] lut [N];
  logic [W-1:0]   h_a [2];
  logic [W-1:0]   h_b [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  approx_mult_err_sweep #(.W(W), .MUL_LAT(0), .SUM_W(SW0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op_a(a0), .op_b(b0), .approx_r(r0),
    .busy(busy0), .done(done0), .err_cnt(cnt0), .sum_ed(sum0), .max_ed(mx0),
    .max_a(ma0), .max_b(mb0));

  approx_mult_err_sweep #(.W(W), .MUL_LAT(2), .SUM_W(SW2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .op_a(a2), .op_b(b2), .approx_r(r2),
    .busy(busy2), .done(done2), .err_cnt(cnt2), .sum_ed(sum2), .max_ed(mx2),
    .max_a(ma2), .max_b(mb2));

  // Multiplier under test models; mode 3 is a random lookup table.
  function automatic logic [2*W-1:0] model_r(input int m, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [2*W-1:0] lv);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (m)
      0:       return p;
      1:       return p & ~(2*W)'(1);
      2:       return '0;
      default: return lv;
    endcase
  endfunction

  always @(posedge clk) begin
    h_a[0] <= a2;
    h_b[0] <= b2;
    h_a[1] <= h_a[0];
    h_b[1] <= h_b[0];
  end

  always_comb r0 = model_r(mode, a0, b0, lut[{a0, b0}]);

  always_comb begin
    r2 = '0;
    if (mis2 != 0) r2 = model_r(mode, h_a[0], h_b[0], lut[{h_a[0], h_b[0]}]);
    else           r2 = model_r(mode, h_a[1], h_b[1], lut[{h_a[1], h_b[1]}]);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference value of R for pair index j (j = A*2^W + B).
  function automatic longint ref_r(input int m, input int j);
    longint p;
    p = longint'(j / (1 << W)) * longint'(j % (1 << W));
    case (m)
      0:       return p;
      1:       return p - (p % 2);
      2:       return 0;
      default: return longint'(lut[j]);
    endcase
  endfunction

  // Pair k is compared with the R of pair k+shift (operands hold at the last pair).
  function automatic stats_t ref_stats(input int m, input int shift, input int sw);
    stats_t s;
    longint ex, rv, ed;
    int     j;
    s = '{cnt: 0, sum: 0, mx: 0, ma: 0, mb: 0};
    for (int k = 0; k < N; k++) begin
      j  = (k + shift > N - 1) ? N - 1 : k + shift;
      ex = longint'(k / (1 << W)) * longint'(k % (1 << W));
      rv = ref_r(m, j);
      ed = (ex > rv) ? ex - rv : rv - ex;
      if (ed != 0) s.cnt++;
      s.sum += ed;
      if (ed > s.mx) begin
        s.mx = ed;
        s.ma = k / (1 << W);
        s.mb = k % (1 << W);
      end
    end
    s.sum = s.sum % (longint'(1) << sw);
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy_done"}, {busy0, done0, busy2, done2}, 0);
    check({tag, "_ops"},       {a0, b0, a2, b2}, 0);
    check({tag, "_stats0"},    longint'(cnt0) | longint'(sum0) | longint'(mx0) | longint'({ma0, mb0}), 0);
    check({tag, "_stats2"},    longint'(cnt2) | longint'(sum2) | longint'(mx2) | longint'({ma2, mb2}), 0);
  endtask

  task automatic run_sweep(input string name, input int pulse_at);
    int     order_err, lat0, lat2, idx;
    stats_t e0, e2;
    order_err = 0;
    lat0 = -1;
    lat2 = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_start_state"}, {busy0, done0, busy2, done2}, 4'b1010);
    check({name, "_start_clear"}, longint'(cnt0) | longint'(sum0) | longint'(mx0) |
                                  longint'(cnt2) | longint'(sum2) | longint'(mx2), 0);
    if ({a0, b0} != 0 || {a2, b2} != 0) order_err++;
    for (int n = 1; n <= N + 20; n++) begin
      @(posedge clk);
      #1 start = (n == pulse_at);
      idx = (n < N) ? n : N - 1;
      if (busy0 && (int'({a0, b0}) != idx)) order_err++;
      if (busy2 && (int'({a2, b2}) != idx)) order_err++;
      if (lat0 < 0 && done0) lat0 = n;
      if (lat2 < 0 && done2) lat2 = n;
      if (lat0 >= 0 && lat2 >= 0) break;
    end
    start = 1'b0;
    check({name, "_order"}, order_err, 0);
    check({name, "_lat0"}, lat0, N + 3);
    check({name, "_lat2"}, lat2, N + 5);
    e0 = ref_stats(mode, 0, SW0);
    e2 = ref_stats(mode, mis2, SW2);
    check({name, "_cnt0"}, cnt0, e0.cnt);
    check({name, "_sum0"}, sum0, e0.sum);
    check({name, "_max0"}, mx0, e0.mx);
    check({name, "_maxab0"}, {ma0, mb0}, e0.ma * (1 << W) + e0.mb);
    check({name, "_cnt2"}, cnt2, e2.cnt);
    check({name, "_sum2"}, sum2, e2.sum);
    check({name, "_max2"}, mx2, e2.mx);
    check({name, "_maxab2"}, {ma2, mb2}, e2.ma * (1 << W) + e2.mb);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    mis2  = 0;
    for (int i = 0; i < N; i++) lut[i] = '0;

    #12 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("idle");

    mode = 0; run_sweep("exact", 0);
    mode = 1; run_sweep("lsb_drop_restart_ignored", 100);
    mode = 2; run_sweep("zero", 0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++)
        lut[i] = ($urandom_range(0, 3) == 0) ? (2*W)'($urandom)
                                              : (2*W)'((i / (1 << W)) * (i % (1 << W)));
      mode = 3;
      run_sweep($sformatf("rand_lut%0d", t), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, N)) : 0);
    end

    mode = 0; mis2 = 1;
    run_sweep("misaligned", 0);
    check("misaligned_nonzero", (cnt2 != 0), 1);
    mis2 = 0;

    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat ($urandom_range(40, 200)) @(posedge clk);
    #($urandom_range(1, 8)) rst = 1'b1;
    #1 check_all_zero("rst_mid_sweep");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all_zero("rst_release");
    run_sweep("after_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
